// File: rtl/period_sweep_controller.sv
`default_nettype none
// ============================================================================
// Module      : period_sweep_controller
// Description : Steps the monitor period setting upward from a clamped start
//               value and locks on the largest setting that showed no failure.
// Revision    : 1.0 - initial release
// ============================================================================
module period_sweep_controller #(
    parameter int WIDTH         = 8,
    parameter int STEP          = 1,
    parameter int SETTLE_CYCLES = 256,
    parameter int OBS_CYCLES    = 512
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] psi_start,
    input  logic [WIDTH-1:0] psi_min,
    input  logic [WIDTH-1:0] psi_max,
    input  logic             fail_async,
    output logic [WIDTH-1:0] psi_set,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic             at_limit,
    output logic [WIDTH-1:0] locked_period
);

    localparam int CNT_MAX = (SETTLE_CYCLES > OBS_CYCLES) ? SETTLE_CYCLES : OBS_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] c_SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_OBS_LAST    = CNT_W'(OBS_CYCLES - 1);
    localparam logic [WIDTH-1:0] c_STEP        = WIDTH'(STEP);
    localparam logic [WIDTH:0]   c_STEP_EXT    = (WIDTH + 1)'(STEP);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETTLE  = 3'd1;
    localparam logic [2:0] ST_OBSERVE = 3'd2;
    localparam logic [2:0] ST_DECIDE  = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] psi_set_q, psi_set_d;
    logic [WIDTH-1:0] locked_q, locked_d;
    logic [WIDTH-1:0] last_good_q, last_good_d;
    logic [WIDTH-1:0] max_q, max_d;
    logic             last_good_valid_q, last_good_valid_d;
    logic             seen_fail_q, seen_fail_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic             at_limit_q, at_limit_d;
    logic [1:0]       sync_q;

    logic             w_fail_s;
    logic [WIDTH-1:0] w_clamped;
    logic             w_over_limit;

    assign w_fail_s = sync_q[1];

    // Applying the ceiling last makes psi_max win when the clamps are inverted.
    always_comb begin
        w_clamped = psi_start;
        if (psi_start < psi_min) w_clamped = psi_min;
        if (w_clamped > psi_max) w_clamped = psi_max;
    end

    assign w_over_limit = ({1'b0, psi_set_q} + c_STEP_EXT) > {1'b0, max_q};

    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        psi_set_d         = psi_set_q;
        locked_d          = locked_q;
        last_good_d       = last_good_q;
        max_d             = max_q;
        last_good_valid_d = last_good_valid_q;
        seen_fail_d       = seen_fail_q;
        busy_d            = busy_q;
        done_d            = done_q;
        error_d           = error_q;
        at_limit_d        = at_limit_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    psi_set_d         = w_clamped;
                    max_d             = psi_max;
                    cnt_d             = '0;
                    seen_fail_d       = 1'b0;
                    last_good_valid_d = 1'b0;
                    busy_d            = 1'b1;
                    done_d            = 1'b0;
                    error_d           = 1'b0;
                    at_limit_d        = 1'b0;
                    state_d           = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == c_SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_OBSERVE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_OBSERVE: begin
                seen_fail_d = seen_fail_q | w_fail_s;
                if (cnt_q == c_OBS_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_DECIDE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DECIDE: begin
                if (seen_fail_q) begin
                    if (last_good_valid_q) begin
                        psi_set_d = last_good_q;
                        locked_d  = last_good_q;
                    end else begin
                        error_d  = 1'b1;
                        locked_d = psi_set_q;
                    end
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    last_good_d       = psi_set_q;
                    last_good_valid_d = 1'b1;
                    if (w_over_limit) begin
                        at_limit_d = 1'b1;
                        locked_d   = psi_set_q;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        state_d    = ST_DONE;
                    end else begin
                        psi_set_d   = psi_set_q + c_STEP;
                        seen_fail_d = 1'b0;
                        state_d     = ST_SETTLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // psi_min is a static configuration input, so it doubles as the reset value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q           <= ST_IDLE;
            cnt_q             <= '0;
            psi_set_q         <= psi_min;
            locked_q          <= '0;
            last_good_q       <= '0;
            max_q             <= '0;
            last_good_valid_q <= 1'b0;
            seen_fail_q       <= 1'b0;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
            error_q           <= 1'b0;
            at_limit_q        <= 1'b0;
            sync_q            <= 2'b00;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            psi_set_q         <= psi_set_d;
            locked_q          <= locked_d;
            last_good_q       <= last_good_d;
            max_q             <= max_d;
            last_good_valid_q <= last_good_valid_d;
            seen_fail_q       <= seen_fail_d;
            busy_q            <= busy_d;
            done_q            <= done_d;
            error_q           <= error_d;
            at_limit_q        <= at_limit_d;
            sync_q            <= {sync_q[0], fail_async};
        end
    end

    assign psi_set       = psi_set_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign at_limit      = at_limit_q;
    assign locked_period = locked_q;

endmodule
`default_nettype wire

// File: tb/tb_period_sweep_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_period_sweep_controller
// Description : Directed bench for period_sweep_controller with short timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_period_sweep_controller;

    localparam int c_WIDTH = 8;

    logic               clk;
    logic               rst;
    logic               start;
    logic [c_WIDTH-1:0] psi_start;
    logic [c_WIDTH-1:0] psi_min;
    logic [c_WIDTH-1:0] psi_max;
    logic               fail_async;
    logic [c_WIDTH-1:0] psi_set;
    logic               busy;
    logic               done;
    logic               error;
    logic               at_limit;
    logic [c_WIDTH-1:0] locked_period;

    // 0: never fail, 1: fail at psi_set >= 103, 2: always fail, 3: manual pulse
    int   r_fail_mode;
    logic r_fail_pulse;

    int r_checks;
    int r_errors;

    period_sweep_controller #(
        .WIDTH        (c_WIDTH),
        .STEP         (1),
        .SETTLE_CYCLES(4),
        .OBS_CYCLES   (8)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .psi_start    (psi_start),
        .psi_min      (psi_min),
        .psi_max      (psi_max),
        .fail_async   (fail_async),
        .psi_set      (psi_set),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .at_limit     (at_limit),
        .locked_period(locked_period)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        fail_async = 1'b0;
        case (r_fail_mode)
            1:       fail_async = (psi_set >= 8'd103);
            2:       fail_async = 1'b1;
            3:       fail_async = r_fail_pulse;
            default: fail_async = 1'b0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        r_checks++;
        if (got !== exp) begin
            r_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input logic [7:0] s, input logic [7:0] mn, input logic [7:0] mx);
        psi_start = s;
        psi_min   = mn;
        psi_max   = mx;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 300) begin
            tick();
            n++;
        end
        if (!done) check({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        r_checks     = 0;
        r_errors     = 0;
        r_fail_mode  = 0;
        r_fail_pulse = 1'b0;
        start        = 1'b0;
        psi_start    = 8'd100;
        psi_min      = 8'd60;
        psi_max      = 8'd190;
        rst          = 1'b1;
        tick();
        tick();
        check("rst_psi_set", psi_set, 60);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_locked", locked_period, 0);
        rst = 1'b0;
        tick();

        // Fail appears at 103 -> restore to 102
        r_fail_mode = 1;
        kick(8'd100, 8'd60, 8'd190);
        check("t1_busy", busy, 1);
        check("t1_first_psi", psi_set, 100);
        wait_done("t1");
        check("t1_locked", locked_period, 102);
        check("t1_psi_set", psi_set, 102);
        check("t1_error", error, 0);
        check("t1_at_limit", at_limit, 0);
        check("t1_busy_end", busy, 0);

        // Clamp low, reach ceiling cleanly
        r_fail_mode = 0;
        kick(8'd50, 8'd60, 8'd63);
        check("t2_first_psi", psi_set, 60);
        check("t2_done_clr", done, 0);
        wait_done("t2");
        check("t2_at_limit", at_limit, 1);
        check("t2_locked", locked_period, 63);
        check("t2_psi_set", psi_set, 63);
        check("t2_error", error, 0);

        // Clamp high, first step fails
        r_fail_mode = 2;
        kick(8'd200, 8'd60, 8'd190);
        check("t3_first_psi", psi_set, 190);
        wait_done("t3");
        check("t3_error", error, 1);
        check("t3_locked", locked_period, 190);
        check("t3_psi_set", psi_set, 190);
        check("t3_at_limit", at_limit, 0);

        // Glitch confined to SETTLE is ignored
        r_fail_mode = 3;
        kick(8'd100, 8'd60, 8'd101);
        r_fail_pulse = 1'b1;
        tick();
        r_fail_pulse = 1'b0;
        wait_done("t4a");
        check("t4a_error", error, 0);
        check("t4a_at_limit", at_limit, 1);
        check("t4a_locked", locked_period, 101);

        // Glitch inside the second step's OBSERVE window fails that step
        kick(8'd100, 8'd60, 8'd120);
        repeat (19) tick();
        check("t4b_psi_step2", psi_set, 101);
        r_fail_pulse = 1'b1;
        tick();
        r_fail_pulse = 1'b0;
        wait_done("t4b");
        check("t4b_locked", locked_period, 100);
        check("t4b_psi_set", psi_set, 100);
        check("t4b_error", error, 0);

        // Start while busy is ignored; start in DONE restarts
        r_fail_mode = 0;
        kick(8'd60, 8'd60, 8'd63);
        tick();
        kick(8'd62, 8'd60, 8'd63);
        check("t5_no_restart", psi_set, 60);
        tick();
        check("t5_still_60", psi_set, 60);
        wait_done("t5");
        check("t5_locked", locked_period, 63);
        kick(8'd61, 8'd60, 8'd63);
        check("t5_done_drop", done, 0);
        check("t5_busy_rise", busy, 1);
        check("t5_restart_psi", psi_set, 61);
        wait_done("t5b");
        check("t5b_locked", locked_period, 63);

        // Async reset mid-OBSERVE
        kick(8'd100, 8'd60, 8'd190);
        repeat (8) tick();
        rst = 1'b1;
        #1;
        check("t6_psi_set", psi_set, 60);
        check("t6_busy", busy, 0);
        check("t6_locked", locked_period, 0);
        check("t6_done", done, 0);
        tick();
        rst = 1'b0;
        tick();
        kick(8'd61, 8'd60, 8'd63);
        wait_done("t6b");
        check("t6b_at_limit", at_limit, 1);
        check("t6b_locked", locked_period, 63);

        $display("Result: errors=%0d of %0d checks", r_errors, r_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/period_sweep_controller.md
Name: period_sweep_controller

Overview:
- Sequences the clock-monitor datapath. Sweeps the period setting (psi_set) upward one step at a time from a start value.
- Settles and observes the monitor's Fail flag at each step. Locks on the largest setting that passed.
- Sits between the configuration switches and the monitor/clock-generator pair; runs in the clk50 domain.

Parameters:
- WIDTH, 8, width of all period settings.
- STEP, 1, increment applied per sweep step.
- SETTLE_CYCLES, 256, clk cycles waited after each new setting before observing.
- OBS_CYCLES, 512, clk cycles during which fail is sampled per step.

Ports:
- clk  input  1  system clock (clk50 domain)
- rst  input  1  asynchronous, active-high reset
- start  input  1  single-cycle request to begin a sweep
- psi_start  input  WIDTH  first setting to try
- psi_min  input  WIDTH  lower clamp
- psi_max  input  WIDTH  upper clamp / sweep ceiling
- fail_async  input  1  Fail from the monitor (clk_ex domain, asynchronous here)
- psi_set  output  WIDTH  setting driven to the monitor
- busy  output  1  sweep in progress
- done  output  1  sweep finished (held until next start)
- error  output  1  start setting already failed
- at_limit  output  1  sweep reached psi_max without failing
- locked_period  output  WIDTH  final passing setting

Behaviour:
- Reset (async, active-high):
  - State IDLE; psi_set=psi_min; locked_period=0; busy=done=error=at_limit=0.
  - Counters cleared; sync flops cleared; last_good_valid=0.
- fail_async passes through a 2-flop synchronizer (fail_s); the FSM never uses it raw. Sync latency: 2 cycles.
- Clamp rule for psi_start:
  - < psi_min gives psi_min.
  - > psi_max gives psi_max.
  - Otherwise psi_start, including equality.
  - If psi_min > psi_max, psi_max wins.
- States:
  - IDLE:
    - On start: load psi_set with the clamped psi_start; clear done/error/at_limit and last_good_valid; busy=1 next cycle; go SETTLE.
  - SETTLE:
    - Count SETTLE_CYCLES cycles, then clear the counter and go OBSERVE.
    - fail_s is ignored.
  - OBSERVE:
    - Count OBS_CYCLES cycles. A sticky seen_fail flag is set if fail_s=1 on any cycle.
    - On the last count go DECIDE.
  - DECIDE (1 cycle):
    - seen_fail=1 and last_good_valid=1: psi_set <= last_good; locked_period <= last_good; go DONE.
    - seen_fail=1 and last_good_valid=0: error=1; locked_period <= psi_set; go DONE.
    - seen_fail=0: last_good <= psi_set; last_good_valid=1.
      - If psi_set > psi_max - STEP (no wrap; compare in WIDTH+1 bits): at_limit=1; locked_period <= psi_set; go DONE.
      - Else psi_set <= psi_set + STEP; clear seen_fail; go SETTLE.
  - DONE:
    - busy=0, done=1; psi_set holds locked value.
    - start restarts exactly as from IDLE.
- start while busy is ignored. Changes to psi_min/psi_max/psi_start mid-sweep take effect only at the next start.
- The sweep is monotonic: psi_set never decreases except for the single restore to last_good.
- Per-step latency: SETTLE_CYCLES + OBS_CYCLES + 1 cycles.
- Reset mid-sweep returns to IDLE immediately; all outputs take their reset values.
- Outputs are registered, with no combinational path from inputs to outputs.

Test Plan:
- SETTLE=4, OBS=8, min=60, max=190, start=100; fail_s goes high once psi_set≥103 -> psi_set steps 100,101,102,103. Then done=1, locked_period=102, psi_set=102, error=0.
- start=50, min=60, fail never asserted, max=63 -> sweep 60..63. Then at_limit=1, locked_period=63, done=1.
- start=200, max=190, fail held high -> psi_set=190, error=1, done=1, locked_period=190. Also covers clamp-high.
- Single-cycle fail_async glitch in SETTLE only -> ignored; sweep continues. Same glitch mid-OBSERVE -> step treated as fail.
- start pulsed again while busy -> no restart, sweep unchanged. Then start in DONE -> fresh sweep, done deasserts next cycle.
- rst asserted asynchronously mid-OBSERVE -> immediate reset values (psi_set=psi_min, busy=0). Next start runs normally.
